replay_rd_sched: RTL

REPLAY_RD_SCHED -- requirements
Module: replay_rd_sched

---
 rtl/replay_rd_sched_if.sv | 15 +
 rtl/replay_rd_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/replay_rd_sched_if.sv
// Read-request channel between the replay scheduler and the memory controller.
// Handshake: a request transfers on any rising edge with rd_valid=1 and rd_ready=1; once
// rd_valid is raised, rd_valid/rd_addr/rd_qid stay fixed until that transfer (or reset).
interface replay_rd_sched_if #(
    parameter int ADDR_W = 19,
    parameter int QID_W  = 2
) ();
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [QID_W-1:0]  rd_qid;

    modport master (output rd_valid, output rd_addr, output rd_qid, input rd_ready);
    modport slave  (input rd_valid, input rd_addr, input rd_qid, output rd_ready);
endinterface

// File: rtl/replay_rd_sched.sv
// Round-robin read scheduler that replays per-queue address ranges a configured number of
// passes, issuing one burst-address request per transfer on a registered valid/ready channel.
module replay_rd_sched #(
    parameter int C_NUM_QUEUES       = 4,
    parameter int QDR_ADDR_WIDTH     = 19,
    parameter int REPLAY_COUNT_WIDTH = 32,
    parameter int ADDR_STEP          = 2
) (
    input  logic                                     axi_aclk,
    input  logic                                     sw_rst,
    input  logic [C_NUM_QUEUES-1:0]                  enable,
    input  logic [C_NUM_QUEUES*QDR_ADDR_WIDTH-1:0]     mem_ad_low,
    input  logic [C_NUM_QUEUES*QDR_ADDR_WIDTH-1:0]     mem_ad_high,
    input  logic [C_NUM_QUEUES*REPLAY_COUNT_WIDTH-1:0] replay_count,
    input  logic [C_NUM_QUEUES-1:0]                  q_full,
    replay_rd_sched_if.master                        rd,
    output logic [C_NUM_QUEUES-1:0]                  done,
    output logic [C_NUM_QUEUES-1:0]                  cfg_err,
    output logic [2*C_NUM_QUEUES-1:0]                state_dbg
);
    localparam int AW    = QDR_ADDR_WIDTH;
    localparam int RCW   = REPLAY_COUNT_WIDTH;
    localparam int QID_W = (C_NUM_QUEUES > 1) ? $clog2(C_NUM_QUEUES) : 1;
    localparam logic [AW:0] STEP_EXT = (QDR_ADDR_WIDTH+1)'(ADDR_STEP);

    typedef enum logic [1:0] {
        Q_IDLE   = 2'd0,
        Q_ACTIVE = 2'd1,
        Q_DONE   = 2'd2
    } q_state_t;

    logic                   xfer;
    logic [C_NUM_QUEUES-1:0] elig;
    logic [AW-1:0]          cand_addr [C_NUM_QUEUES];
    logic [QID_W-1:0]       rr_ptr;
    logic                   gnt_found;
    logic [QID_W-1:0]       gnt_idx;
    logic [AW-1:0]          gnt_addr;

    assign xfer = rd.rd_valid && rd.rd_ready;

    for (genvar q = 0; q < C_NUM_QUEUES; q++) begin : g_q
        q_state_t         st;
        q_state_t         post_state;
        logic [AW-1:0]    cur_addr;
        logic [AW-1:0]    low_l;
        logic [AW-1:0]    high_l;
        logic [AW-1:0]    post_addr;
        logic [RCW-1:0]   remaining;
        logic [RCW-1:0]   post_rem;
        logic [AW:0]      nxt_ext;
        logic             pass_end;
        logic             is_pend;
        logic             hold_q;
        logic             xfer_q;
        logic             done_r;
        logic             err_r;
        logic [AW-1:0]    low_in;
        logic [AW-1:0]    high_in;
        logic [RCW-1:0]   cnt_in;

        assign low_in  = mem_ad_low[q*AW +: AW];
        assign high_in = mem_ad_high[q*AW +: AW];
        assign cnt_in  = replay_count[q*RCW +: RCW];

        // One extra bit so a step past the top of memory ends the pass instead of wrapping.
        assign nxt_ext  = {1'b0, cur_addr} + STEP_EXT;
        assign pass_end = nxt_ext > {1'b0, high_l};

        always_comb begin
            post_addr  = nxt_ext[AW-1:0];
            post_rem   = remaining;
            post_state = Q_ACTIVE;
            if (pass_end) begin
                post_addr = low_l;
                post_rem  = remaining - 1'b1;
                if (remaining <= RCW'(1)) post_state = Q_DONE;
            end
        end

        assign is_pend = rd.rd_valid && (rd.rd_qid == QID_W'(q));
        assign xfer_q  = is_pend && rd.rd_ready;
        assign hold_q  = is_pend && !rd.rd_ready;

        // A queue being presented competes again only with its post-transfer state.
        assign elig[q] = enable[q] && !q_full[q] &&
                         (is_pend ? (xfer && post_state == Q_ACTIVE) : (st == Q_ACTIVE));
        assign cand_addr[q] = is_pend ? post_addr : cur_addr;

        always_ff @(posedge axi_aclk) begin
            if (sw_rst) begin
                st        <= Q_IDLE;
                cur_addr  <= '0;
                low_l     <= '0;
                high_l    <= '0;
                remaining <= '0;
                done_r    <= 1'b0;
                err_r     <= 1'b0;
            end else if (!enable[q]) begin
                if (!hold_q) begin
                    st     <= Q_IDLE;
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                end
            end else begin
                case (st)
                    Q_IDLE: begin
                        low_l     <= low_in;
                        high_l    <= high_in;
                        remaining <= cnt_in;
                        cur_addr  <= low_in;
                        if (cnt_in == '0 || low_in > high_in) begin
                            st     <= Q_DONE;
                            done_r <= 1'b1;
                            err_r  <= (low_in > high_in);
                        end else begin
                            st <= Q_ACTIVE;
                        end
                    end
                    Q_ACTIVE: begin
                        if (xfer_q) begin
                            cur_addr  <= post_addr;
                            remaining <= post_rem;
                            st        <= post_state;
                            if (post_state == Q_DONE) done_r <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign done[q]             = done_r;
        assign cfg_err[q]          = err_r;
        assign state_dbg[2*q +: 2] = st;
    end

    always_comb begin
        logic [QID_W:0] sum;
        logic [QID_W-1:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_addr  = '0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < C_NUM_QUEUES; i++) begin
            sum = {1'b0, rr_ptr} + (QID_W+1)'(i);
            if (sum >= (QID_W+1)'(C_NUM_QUEUES)) sum = sum - (QID_W+1)'(C_NUM_QUEUES);
            idx = sum[QID_W-1:0];
            if (!gnt_found && elig[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
                gnt_addr  = cand_addr[idx];
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (sw_rst) begin
            rd.rd_valid <= 1'b0;
            rd.rd_addr  <= '0;
            rd.rd_qid   <= '0;
            rr_ptr      <= '0;
        end else if (!rd.rd_valid || rd.rd_ready) begin
            if (gnt_found) begin
                rd.rd_valid <= 1'b1;
                rd.rd_addr  <= gnt_addr;
                rd.rd_qid   <= gnt_idx;
                rr_ptr      <= (gnt_idx == QID_W'(C_NUM_QUEUES-1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                rd.rd_valid <= 1'b0;
            end
        end
    end
endmodule
